// File: rtl/async_queue_source_stage.sv
// Source (write) half of a clock-domain-crossing queue: buffers enqueued beats,
// publishes a Gray write index and tracks the sink's Gray read index for flow control.
module async_queue_source_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int SYNC  = 3,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [WIDTH-1:0]       enq_bits,
  output logic [DEPTH*WIDTH-1:0] async_mem,
  output logic [AW:0]            async_widx,
  input  logic [AW:0]            async_ridx,
  input  logic                   async_safe_ridx_valid,
  output logic                   async_safe_widx_valid,
  output logic                   async_safe_source_reset_n
);

  // Top two index bits inverted, remaining bits equal: writer is a full lap ahead.
  localparam logic [AW:0] FULL_MASK = (AW+1)'(3) << (AW - 1);

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [AW:0]                widx_bin;
  logic [AW:0]                widx_bin_inc;
  logic [SYNC-1:0][AW:0]      ridx_sync;
  logic [SYNC-1:0]            valid_sync;
  logic [AW:0]                ridx_s;
  logic                       sink_ready;
  logic                       sink_ready_next;
  logic                       full;
  logic                       fire;
  logic [WIDTH-1:0]           mem [DEPTH];

  assign ridx_s          = ridx_sync[SYNC-1];
  assign sink_ready      = valid_sync[SYNC-1];
  // Value sink_ready takes on the coming edge; clearing on it lets the index
  // reset land on the same edge the flag falls, beating any fire on that edge.
  assign sink_ready_next = valid_sync[SYNC-2];
  assign widx_bin_inc    = widx_bin + (AW+1)'(1);
  assign full            = (to_gray(widx_bin) == (ridx_s ^ FULL_MASK));
  assign enq_ready       = sink_ready & ~full;
  assign fire            = enq_valid & enq_ready;

  // Per-bit synchronizers; Gray coding guarantees at most one ridx bit in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ridx_sync  <= '0;
      valid_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's pre-edge value; blocking here would collapse the chain to one flop.
      ridx_sync  <= {ridx_sync[SYNC-2:0], async_ridx};
      valid_sync <= {valid_sync[SYNC-2:0], async_safe_ridx_valid};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      widx_bin                  <= '0;
      async_widx                <= '0;
      async_safe_widx_valid     <= 1'b0;
      async_safe_source_reset_n <= 1'b0;
    end else begin
      async_safe_widx_valid     <= 1'b1;
      async_safe_source_reset_n <= 1'b1;
      if (!sink_ready_next) begin
        widx_bin   <= '0;
        async_widx <= '0;
      end else if (fire) begin
        widx_bin   <= widx_bin_inc;
        async_widx <= to_gray(widx_bin_inc);
      end
    end
  end

  // NOTE: the buffer is deliberately left out of reset; the sink never reads an
  // entry the write index has not advertised, and a reset port would block RAM mapping.
  always_ff @(posedge clock) begin
    if (fire) mem[widx_bin[AW-1:0]] <= enq_bits;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem_out
    assign async_mem[i*WIDTH +: WIDTH] = mem[i];
  end

endmodule

// File: tb/tb_async_queue_source_stage.sv
// Directed bench for async_queue_source_stage: occupancy-based queue model checked
// every cycle, plus literal expectations from hand-worked scenarios.
module tb_async_queue_source_stage;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int AW    = 3;
  localparam int MOD   = 2 * DEPTH;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic                   enq_valid;
  logic                   enq_ready;
  logic [WIDTH-1:0]       enq_bits;
  logic [DEPTH*WIDTH-1:0] async_mem;
  logic [AW:0]            async_widx;
  logic [AW:0]            async_ridx;
  logic                   async_safe_ridx_valid;
  logic                   async_safe_widx_valid;
  logic                   async_safe_source_reset_n;

  async_queue_source_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .enq_valid                 (enq_valid),
    .enq_ready                 (enq_ready),
    .enq_bits                  (enq_bits),
    .async_mem                 (async_mem),
    .async_widx                (async_widx),
    .async_ridx                (async_ridx),
    .async_safe_ridx_valid     (async_safe_ridx_valid),
    .async_safe_widx_valid     (async_safe_widx_valid),
    .async_safe_source_reset_n (async_safe_source_reset_n)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: write count, sink samples delayed by SYNC edges ----------------
  int              wcount = 0;
  bit              alive  = 0;
  logic [WIDTH-1:0] mmem [DEPTH];
  bit              mvalid [DEPTH];
  logic [AW:0]     rq [$];
  bit              sq [$];

  function automatic logic [AW:0] gray(input int b);
    int m = b % MOD;
    return (AW+1)'(m ^ (m >> 1));
  endfunction

  function automatic int ungray(input logic [AW:0] g);
    int b = 0;
    for (int i = AW; i >= 0; i--) b = (b << 1) | int'(^(g >> i));
    return b;
  endfunction

  function automatic bit model_sink();
    return (sq.size() == SYNC) ? sq[0] : 1'b0;
  endfunction

  function automatic bit model_ready();
    int r   = (rq.size() == SYNC) ? ungray(rq[0]) : 0;
    int occ = (wcount - r + MOD) % MOD;
    return model_sink() && (occ != DEPTH);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcount = 0;
      alive  = 0;
      rq.delete();
      sq.delete();
    end else begin
      bit fire;
      fire = enq_valid && model_ready();
      if (fire) begin
        mmem[wcount % DEPTH]   = enq_bits;
        mvalid[wcount % DEPTH] = 1'b1;
      end
      rq.push_back(async_ridx);
      sq.push_back(async_safe_ridx_valid);
      if (rq.size() > SYNC) void'(rq.pop_front());
      if (sq.size() > SYNC) void'(sq.pop_front());
      if (!model_sink()) wcount = 0;
      else if (fire)     wcount = (wcount + 1) % MOD;
      alive = 1;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clock) begin
    check("enq_ready",   {63'b0, enq_ready}, {63'b0, model_ready()});
    check("async_widx",  64'(async_widx), 64'(gray(wcount)));
    check("widx_valid",  {63'b0, async_safe_widx_valid}, {63'b0, alive});
    check("src_reset_n", {63'b0, async_safe_source_reset_n}, {63'b0, alive});
    for (int i = 0; i < DEPTH; i++)
      if (mvalid[i]) check($sformatf("mem[%0d]", i), 64'(async_mem[i*WIDTH +: WIDTH]), 64'(mmem[i]));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] entry(input int i);
    return async_mem[i*WIDTH +: WIDTH];
  endfunction

  initial begin
    logic [AW:0] fill_seq [8];
    logic [AW:0] prev;
    int          r;
    bit          saw_zero;
    fill_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    reset_n = 1'b0; enq_valid = 1'b0; enq_bits = '0;
    async_ridx = '0; async_safe_ridx_valid = 1'b1;
    repeat (3) tick();
    check("reset_ready", {63'b0, enq_ready}, 64'd0);
    check("reset_widx", 64'(async_widx), 64'd0);
    reset_n = 1'b1;

    // Flags rise one clock after release; ready needs SYNC clocks.
    tick();
    check("up_widx_valid", {63'b0, async_safe_widx_valid}, 64'd1);
    check("up_src_reset_n", {63'b0, async_safe_source_reset_n}, 64'd1);
    check("up_ready_1", {63'b0, enq_ready}, 64'd0);
    tick();
    check("up_ready_2", {63'b0, enq_ready}, 64'd0);
    tick();
    check("up_ready_3", {63'b0, enq_ready}, 64'd1);

    // Fill all DEPTH entries.
    enq_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      enq_bits = 32'hA0 + 32'(i);
      tick();
      check($sformatf("fill_widx_%0d", i), 64'(async_widx), 64'(fill_seq[i]));
    end
    check("full_ready", {63'b0, enq_ready}, 64'd0);
    check("fill_entry3", 64'(entry(3)), 64'hA3);
    enq_bits = 32'hEE;
    repeat (2) tick();
    check("full_hold_widx", 64'(async_widx), 64'hC);
    check("full_hold_entry0", 64'(entry(0)), 64'hA0);
    enq_valid = 1'b0;

    // Sink consumes one entry; space appears after SYNC clocks.
    async_ridx = 4'h1;
    repeat (SYNC - 1) tick();
    check("drain_ready_early", {63'b0, enq_ready}, 64'd0);
    tick();
    check("drain_ready", {63'b0, enq_ready}, 64'd1);
    enq_valid = 1'b1; enq_bits = 32'hB0;
    tick();
    enq_valid = 1'b0;
    check("drain_widx", 64'(async_widx), 64'hD);
    check("drain_entry0", 64'(entry(0)), 64'hB0);

    // Full lap of the index: one bit flips per step, passing through zero.
    r = 1; saw_zero = 0;
    for (int k = 0; k < MOD; k++) begin
      r = (r + 1) % MOD;
      async_ridx = gray(r);
      repeat (SYNC) tick();
      prev = async_widx;
      enq_valid = 1'b1; enq_bits = 32'hC0 + 32'(k);
      tick();
      enq_valid = 1'b0;
      check($sformatf("wrap_onebit_%0d", k), 64'($countones(prev ^ async_widx)), 64'd1);
      if (async_widx == '0) saw_zero = 1;
    end
    check("wrap_saw_zero", {63'b0, saw_zero}, 64'd1);
    check("wrap_end_widx", 64'(async_widx), 64'hD);

    // Sink loss and re-sync at index 0, then advance to widx_bin=5.
    async_safe_ridx_valid = 1'b0;
    repeat (SYNC) tick();
    check("loss1_widx", 64'(async_widx), 64'd0);
    async_ridx = '0; async_safe_ridx_valid = 1'b1;
    repeat (SYNC) tick();
    enq_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      enq_bits = 32'hD0 + 32'(i);
      tick();
    end
    check("pre_loss_widx", 64'(async_widx), 64'h7);
    async_safe_ridx_valid = 1'b0;
    enq_bits = 32'hD5;
    repeat (SYNC - 1) tick();
    check("loss_mid_widx", 64'(async_widx), 64'h4);
    tick();
    check("loss_widx", 64'(async_widx), 64'd0);
    check("loss_ready", {63'b0, enq_ready}, 64'd0);
    tick();
    check("loss_hold_widx", 64'(async_widx), 64'd0);
    enq_valid = 1'b0;

    // Asynchronous reset between edges while a beat is offered.
    async_safe_ridx_valid = 1'b1;
    repeat (SYNC) tick();
    check("pre_rst_ready", {63'b0, enq_ready}, 64'd1);
    enq_valid = 1'b1; enq_bits = 32'hCC;
    #2 reset_n = 1'b0;
    #1;
    check("arst_ready", {63'b0, enq_ready}, 64'd0);
    check("arst_widx", 64'(async_widx), 64'd0);
    check("arst_widx_valid", {63'b0, async_safe_widx_valid}, 64'd0);
    check("arst_src_reset_n", {63'b0, async_safe_source_reset_n}, 64'd0);
    @(posedge clock);
    #1;
    check("arst_no_write", {63'b0, entry(0) == 32'hCC}, 64'd0);
    check("arst_widx_edge", 64'(async_widx), 64'd0);
    enq_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (SYNC + 1) tick();
    check("rerun_ready", {63'b0, enq_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
